// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4-column x 3-row keypad scanner.
// Column index 0..3 maps to strobes B, G, F, D; row index 0..2 maps to C, A, E.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

    localparam logic [3:0] KEY_NONE = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    // One-hot column strobes, packed as {D, F, G, B}
    localparam logic [3:0] COL_B = 4'b0001;
    localparam logic [3:0] COL_G = 4'b0010;
    localparam logic [3:0] COL_F = 4'b0100;
    localparam logic [3:0] COL_D = 4'b1000;

    function automatic logic [3:0] key_code(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        if (col == 2'd3) begin
            case (row)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = ({2'b00, col} * 4'd3) + {2'b00, row} + 4'd1;
        end
        return code;
    endfunction

    function automatic logic [3:0] col_onehot(input logic [1:0] col);
        logic [3:0] strobe;
        case (col)
            2'd0:    strobe = COL_B;
            2'd1:    strobe = COL_G;
            2'd2:    strobe = COL_F;
            default: strobe = COL_D;
        endcase
        return strobe;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the three asynchronous row inputs.
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] raw,
    output logic [2:0] sync
);

    logic [2:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 3'b000;
            sync <= 3'b000;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Timed, debounced keypad scan sequencer with a valid/ack key event port.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
//
// Handshake: KEY_VALID rises with KEY_DATA when a key is reported and stays
// high until KEY_ACK is seen high on a rising edge; KEY_VALID then drops on
// the next cycle. A report in the same cycle as KEY_ACK replaces the event.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int DWELL_CYCLES   = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       C,
    input  logic       A,
    input  logic       E,
    output logic       B,
    output logic       G,
    output logic       F,
    output logic       D,
    output logic       KEY_VALID,
    output logic [3:0] KEY_DATA,
    input  logic       KEY_ACK,
    output logic       OVERRUN,
    output state_t     scan_state
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);

    state_t          state, state_next;
    logic [DW-1:0]   dwell_cnt, dwell_next;
    logic [1:0]      col, col_next;
    logic [3:0]      cand, cand_next;
    logic [MW-1:0]   match_cnt, match_next, match_inc;
    logic [MW-1:0]   rel_cnt, rel_next, rel_inc;
    logic [2:0]      rows;
    logic            sample;
    logic [3:0]      sample_code;
    logic            report;
    logic [3:0]      report_code;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0]   rep_cnt, rep_next, rep_inc;
`endif

    keypad_row_sync u_row_sync (
        .clk  (CLK),
        .rst  (RST),
        .raw  ({E, A, C}),
        .sync (rows)
    );

    assign sample = (dwell_cnt == DW'(DWELL_CYCLES - 1));
    assign {D, F, G, B} = col_onehot(col);
    assign scan_state = state;

    always_comb begin
        sample_code = KEY_NONE;
        if (rows[0])      sample_code = key_code(col, 2'd0);
        else if (rows[1]) sample_code = key_code(col, 2'd1);
        else if (rows[2]) sample_code = key_code(col, 2'd2);
    end

    // Saturating increments: counters stop at the parameter value.
    assign match_inc = (match_cnt == MW'(DEBOUNCE_SCANS)) ? match_cnt : match_cnt + MW'(1);
    assign rel_inc   = (rel_cnt == MW'(DEBOUNCE_SCANS)) ? rel_cnt : rel_cnt + MW'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
    assign rep_inc   = (rep_cnt == RW'(REPEAT_SCANS)) ? rep_cnt : rep_cnt + RW'(1);
`endif

    always_comb begin
        state_next  = state;
        col_next    = col;
        cand_next   = cand;
        match_next  = match_cnt;
        rel_next    = rel_cnt;
        report      = 1'b0;
        report_code = cand;
        dwell_next  = sample ? '0 : dwell_cnt + DW'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_next    = (state == ST_HOLD) ? rep_cnt : '0;
`endif
        if (sample) begin
            case (state)
                ST_SCAN: begin
                    if (sample_code != KEY_NONE) begin
                        cand_next  = sample_code;
                        match_next = MW'(1);
                        rel_next   = '0;
                        if (MW'(DEBOUNCE_SCANS) == MW'(1)) begin
                            report      = 1'b1;
                            report_code = sample_code;
                            state_next  = ST_HOLD;
                        end else begin
                            state_next = ST_DEBOUNCE;
                        end
                    end else begin
                        col_next = col + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (sample_code == cand) begin
                        match_next = match_inc;
                        if (match_inc == MW'(DEBOUNCE_SCANS)) begin
                            report     = 1'b1;
                            state_next = ST_HOLD;
                            rel_next   = '0;
                        end
                    end else begin
                        state_next = ST_SCAN;
                        col_next   = col + 2'd1;
                        match_next = '0;
                    end
                end
                ST_HOLD: begin
                    if (sample_code == KEY_NONE) begin
                        rel_next = rel_inc;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_next = '0;
`endif
                        if (rel_inc == MW'(DEBOUNCE_SCANS)) begin
                            state_next = ST_SCAN;
                            col_next   = col + 2'd1;
                            rel_next   = '0;
                            match_next = '0;
                        end
                    end else begin
                        rel_next = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_inc == RW'(REPEAT_SCANS)) begin
                            report   = 1'b1;
                            rep_next = '0;
                        end else begin
                            rep_next = rep_inc;
                        end
`endif
                    end
                end
                default: state_next = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_SCAN;
            dwell_cnt <= '0;
            col       <= 2'd0;
            cand      <= KEY_NONE;
            match_cnt <= '0;
            rel_cnt   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
            KEY_VALID <= 1'b0;
            KEY_DATA  <= KEY_NONE;
            OVERRUN   <= 1'b0;
        end else begin
            state     <= state_next;
            dwell_cnt <= dwell_next;
            col       <= col_next;
            cand      <= cand_next;
            match_cnt <= match_next;
            rel_cnt   <= rel_next;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= rep_next;
`endif
            // A report beats a simultaneous ack; an unacked event is kept.
            if (report) begin
                if (!KEY_VALID) begin
                    KEY_VALID <= 1'b1;
                    KEY_DATA  <= report_code;
                end else if (KEY_ACK) begin
                    KEY_DATA  <= report_code;
                end else begin
                    OVERRUN   <= 1'b1;
                end
            end else if (KEY_VALID && KEY_ACK) begin
                KEY_VALID <= 1'b0;
                OVERRUN   <= 1'b0;
            end
        end
    end

endmodule
